// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, registered outputs, redirect/discard handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        iq_full,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc_curr,
  output logic [31:0] fetch_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_nx, inst_nx, pc_curr_nx, pc_next_nx;
  logic [31:0] target, target_nx;
  logic [3:0]  rmask_nx;
  logic        valid_nx, discard, discard_nx;
  logic [31:0] redirect_word;

  assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      imem_addr     <= RESET_PC;
      imem_rmask    <= 4'h0;
      fetch_valid   <= 1'b0;
      fetch_inst    <= 32'h0;
      fetch_pc_curr <= 32'h0;
      fetch_pc_next <= 32'h0;
      discard       <= 1'b0;
      target        <= 32'h0;
    end else begin
      state         <= state_nx;
      imem_addr     <= addr_nx;
      imem_rmask    <= rmask_nx;
      fetch_valid   <= valid_nx;
      fetch_inst    <= inst_nx;
      fetch_pc_curr <= pc_curr_nx;
      fetch_pc_next <= pc_next_nx;
      discard       <= discard_nx;
      target        <= target_nx;
    end
  end

  // A redirect while a request is in flight cannot cancel it, so the response is discarded later.
  always_comb begin
    state_nx   = state;
    addr_nx    = imem_addr;
    rmask_nx   = 4'h0;
    valid_nx   = fetch_valid;
    inst_nx    = fetch_inst;
    pc_curr_nx = fetch_pc_curr;
    pc_next_nx = fetch_pc_next;
    discard_nx = discard;
    target_nx  = target;
    if (redirect_valid) begin
      valid_nx = 1'b0;
      if (state == WAIT && !imem_resp) begin
        discard_nx = 1'b1;
        target_nx  = redirect_word;
      end else begin
        state_nx   = WAIT;
        addr_nx    = redirect_word;
        rmask_nx   = 4'hF;
        discard_nx = 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!fetch_valid) begin
            state_nx = WAIT;
            rmask_nx = 4'hF;
          end else if (iq_full) begin
            state_nx = HOLD;
          end else begin
            state_nx = WAIT;
            addr_nx  = fetch_pc_next;
            rmask_nx = 4'hF;
            valid_nx = 1'b0;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            if (discard) begin
              discard_nx = 1'b0;
              addr_nx    = target;
              rmask_nx   = 4'hF;
            end else begin
              state_nx   = IDLE;
              valid_nx   = 1'b1;
              inst_nx    = imem_rdata;
              pc_curr_nx = imem_addr;
              pc_next_nx = imem_addr + 32'd4;
            end
          end
        end
        HOLD: begin
          if (!iq_full) begin
            state_nx = WAIT;
            addr_nx  = fetch_pc_next;
            rmask_nx = 4'hF;
            valid_nx = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic xfer;
  assign xfer = fetch_valid & ~iq_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (xfer)
        perf_fetched <= perf_fetched + 32'd1;
      if (state == HOLD)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, fetch, backpressure, redirects, PC wrap, mid-run reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_full;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc_curr;
  logic [31:0] fetch_pc_next;

  int assertCount = 0;
  int failCount   = 0;

  fetch_stage #(.RESET_PC(32'h1eceb000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iq_full        (iq_full),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .fetch_pc_curr  (fetch_pc_curr),
    .fetch_pc_next  (fetch_pc_next)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, {31'h0, fetch_valid}, 32'h0);
    checkOutput({tag, "_rmask"}, {28'h0, imem_rmask}, 32'h0);
    checkOutput({tag, "_addr"}, imem_addr, 32'h1eceb000);
    checkOutput({tag, "_inst"}, fetch_inst, 32'h0);
    checkOutput({tag, "_pcc"}, fetch_pc_curr, 32'h0);
    checkOutput({tag, "_pcn"}, fetch_pc_next, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_rdata = 32'h0; imem_resp = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; iq_full = 1'b0;
    applyStimulus();
    applyStimulus();
    checkReset("rst");
    rst_n = 1'b1;

    // First request at RESET_PC, then response delivers the first instruction.
    applyStimulus();
    checkOutput("first_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("first_addr", imem_addr, 32'h1eceb000);
    applyStimulus();
    checkOutput("wait_rmask", {28'h0, imem_rmask}, 32'h0);
    imem_resp = 1'b1; imem_rdata = 32'h00000013;
    applyStimulus();
    imem_resp = 1'b0;
    checkOutput("f1_valid", {31'h0, fetch_valid}, 32'h1);
    checkOutput("f1_inst", fetch_inst, 32'h00000013);
    checkOutput("f1_pcc", fetch_pc_curr, 32'h1eceb000);
    checkOutput("f1_pcn", fetch_pc_next, 32'h1eceb004);
    applyStimulus();
    checkOutput("f2_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("f2_addr", imem_addr, 32'h1eceb004);
    checkOutput("f2_valid", {31'h0, fetch_valid}, 32'h0);

    // Backpressure for five cycles.
    imem_resp = 1'b1; imem_rdata = 32'h00100093;
    applyStimulus();
    imem_resp = 1'b0; iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {31'h0, fetch_valid}, 32'h1);
      checkOutput("hold_inst", fetch_inst, 32'h00100093);
      checkOutput("hold_pcc", fetch_pc_curr, 32'h1eceb004);
      checkOutput("hold_pcn", fetch_pc_next, 32'h1eceb008);
      checkOutput("hold_rmask", {28'h0, imem_rmask}, 32'h0);
      applyStimulus();
    end
    iq_full = 1'b0;
    checkOutput("xfer_valid", {31'h0, fetch_valid}, 32'h1);
    applyStimulus();
    checkOutput("xfer_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("xfer_addr", imem_addr, 32'h1eceb008);

    // Redirect while waiting: the in-flight response must be discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h1eceb100;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("rw_valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("rw_rmask", {28'h0, imem_rmask}, 32'h0);
    checkOutput("rw_addr_stable", imem_addr, 32'h1eceb008);
    applyStimulus();
    imem_resp = 1'b1; imem_rdata = 32'hDEADBEEF;
    applyStimulus();
    imem_resp = 1'b0;
    checkOutput("disc_valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("disc_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("disc_addr", imem_addr, 32'h1eceb100);
    applyStimulus();
    checkOutput("disc_valid2", {31'h0, fetch_valid}, 32'h0);

    // Redirect coinciding with response, misaligned target.
    imem_resp = 1'b1; imem_rdata = 32'h11111111;
    redirect_valid = 1'b1; redirect_pc = 32'h1eceb203;
    applyStimulus();
    imem_resp = 1'b0; redirect_valid = 1'b0;
    checkOutput("coin_valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("coin_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("coin_addr", imem_addr, 32'h1eceb200);
    applyStimulus();
    imem_resp = 1'b1; imem_rdata = 32'h00000033;
    applyStimulus();
    imem_resp = 1'b0;
    checkOutput("coin_inst", fetch_inst, 32'h00000033);
    checkOutput("coin_pcc", fetch_pc_curr, 32'h1eceb200);

    // Redirect with no request outstanding beats the pending transfer; exercises PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("wrap_valid0", {31'h0, fetch_valid}, 32'h0);
    checkOutput("wrap_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("wrap_addr", imem_addr, 32'hFFFFFFFC);
    imem_resp = 1'b1; imem_rdata = 32'h00000073;
    applyStimulus();
    imem_resp = 1'b0;
    checkOutput("wrap_pcc", fetch_pc_curr, 32'hFFFFFFFC);
    checkOutput("wrap_pcn", fetch_pc_next, 32'h00000000);
    applyStimulus();
    checkOutput("wrap_next_addr", imem_addr, 32'h00000000);
    checkOutput("wrap_next_rmask", {28'h0, imem_rmask}, 32'hF);

    // Asynchronous reset mid-WAIT, with a stray response during reset.
    rst_n = 1'b0;
    #1;
    checkReset("midrst");
    imem_resp = 1'b1; imem_rdata = 32'hCAFEF00D;
    applyStimulus();
    checkReset("rstresp");
    imem_resp = 1'b0; rst_n = 1'b1;
    applyStimulus();
    checkOutput("rel_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("rel_addr", imem_addr, 32'h1eceb000);

    // Two redirects before the discarded response: the last target wins.
    redirect_valid = 1'b1; redirect_pc = 32'h1eceb300;
    applyStimulus();
    redirect_pc = 32'h1eceb404;
    applyStimulus();
    redirect_valid = 1'b0; imem_resp = 1'b1; imem_rdata = 32'h0BADC0DE;
    applyStimulus();
    imem_resp = 1'b0;
    checkOutput("multi_valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("multi_rmask", {28'h0, imem_rmask}, 32'hF);
    checkOutput("multi_addr", imem_addr, 32'h1eceb404);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
